// File: rtl/serial_shift_unit.sv
// Loadable shift register with a start/busy/done handshake: shifts a parallel word out serially
// (LSB- or MSB-first) while serial input bits fill the vacated end.
module serial_shift_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned LAST_CNT = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             dir_q,   dir_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; busy/done are decoded from the next state so they come straight off flops
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = din;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (dir_q) begin
          data_d = {data_q[WIDTH-2:0], sin};
        end else begin
          data_d = {sin, data_q[WIDTH-1:1]};
        end
        if (cnt_q != CNTW'(WIDTH)) begin
          cnt_d = cnt_q + CNTW'(1);
        end
        if (cnt_q == CNTW'(LAST_CNT)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sout  = dir_q ? data_q[WIDTH-1] : data_q[0];
  assign dout  = data_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: vector table of full shift operations plus
// hand-written sequences for ignored starts, back-to-back operation and mid-run reset.
module tb_serial_shift_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] din;
  logic             dir;
  logic             sin;
  logic             sout;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] din;
    logic       dir;
    logic [7:0] sin_pat;   // bit i is driven before shift edge i+1
    logic [7:0] exp_sout;  // bit i is the i-th bit out
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  serial_shift_unit #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .dir   (dir),
    .sin   (sin),
    .sout  (sout),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One full operation from a table entry; inputs are disturbed after acceptance on purpose
  task automatic run_op(input vec_t v, input int idx);
    @(negedge clk);
    din   = v.din;
    dir   = v.dir;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din   = ~v.din;
    dir   = ~v.dir;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d busy[%0d]", idx, i), 32'(busy), 32'd1);
      chk($sformatf("v%0d done[%0d]", idx, i), 32'(done), 32'd0);
      chk($sformatf("v%0d count[%0d]", idx, i), 32'(count), 32'(i));
      chk($sformatf("v%0d sout[%0d]", idx, i), 32'(sout), 32'(v.exp_sout[i]));
      sin = v.sin_pat[i];
      @(negedge clk);
    end
    chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d dout", idx), 32'(dout), 32'(v.exp_dout));
    chk($sformatf("v%0d count_end", idx), 32'(count), 32'd8);
    sin = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d done_clear", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d dout_hold", idx), 32'(dout), 32'(v.exp_dout));
    chk($sformatf("v%0d count_hold", idx), 32'(count), 32'd8);
  endtask

  initial begin
    int gap;
    int done_seen;
    logic found;

    vecs[0] = '{8'hA5, 1'b0, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{8'h81, 1'b1, 8'hFF, 8'h81, 8'hFF};
    vecs[2] = '{8'h00, 1'b0, 8'h4B, 8'h00, 8'h4B};
    vecs[3] = '{8'h3C, 1'b1, 8'h05, 8'h3C, 8'hA0};
    vecs[4] = '{8'hC6, 1'b0, 8'hFF, 8'hC6, 8'hFF};

    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    dir   = 1'b0;
    sin   = 1'b0;
    #12;
    chk("rst dout", 32'(dout), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst sout", 32'(sout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    for (int k = 0; k < 5; k++) begin
      run_op(vecs[k], k);
    end

    // Start pulses and dir toggles during SHIFT must not restart or redirect
    @(negedge clk);
    din = 8'hA5; dir = 1'b0; sin = 1'b0; start = 1'b1;
    @(negedge clk);
    din = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ign sout[%0d]", i), 32'(sout), 32'(vecs[0].exp_sout[i]));
      chk($sformatf("ign count[%0d]", i), 32'(count), 32'(i));
      chk($sformatf("ign done[%0d]", i), 32'(done), 32'd0);
      start = i[0];
      dir   = ~dir;
      @(negedge clk);
    end
    chk("ign done_pulse", 32'(done), 32'd1);
    chk("ign dout", 32'(dout), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("ign idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ign idle busy2", 32'(busy), 32'd0);
    chk("ign idle done2", 32'(done), 32'd0);

    // Start held high: operations repeat every WIDTH+2 cycles
    din = 8'h0F; dir = 1'b0; sin = 1'b0; start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("b2b first done seen", 32'(found), 32'd1);
    gap = 0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      gap++;
      if (done) found = 1'b1;
    end
    chk("b2b second done seen", 32'(found), 32'd1);
    chk("b2b period", 32'(gap), 32'd10);
    @(negedge clk);
    chk("b2b idle busy", 32'(busy), 32'd0);
    chk("b2b idle done", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b reload busy", 32'(busy), 32'd1);
    chk("b2b reload count", 32'(count), 32'd0);
    chk("b2b reload dout", 32'(dout), 32'h0F);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("b2b 4th shift count", 32'(count), 32'd3);

    // Asynchronous reset in the 4th shift cycle aborts with no done pulse
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("mid rst dout", 32'(dout), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst count", 32'(count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("mid rst no done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
